// File: rtl/seq_divider.sv
// seq_divider: iterative restoring unsigned divider, one quotient bit per clock.
// Recovers quotient and remainder from a DW-bit product and a VW-bit factor,
// which makes it the inverse/check path of the 16x16 multiplier.
//
// Optional feature macro: DIV_ZERO_DETECT_EN
//   defined   : a zero divisor at accept skips the iteration, goes straight to
//               DONE (out_valid visible in the cycle after the accepting edge)
//               and raises div_zero with quotient=all ones, remainder=dividend[VW-1:0].
//   undefined : div_zero is tied low; a zero divisor runs the full DW
//               iterations and naturally produces the same quotient/remainder.
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid and ready are both high. in_ready is high only in IDLE. out_valid is
// high only in DONE and, once raised, stays high with quotient/remainder/
// div_zero frozen until the edge where out_ready is sampled high. in_ready
// comes back in the cycle after that edge, so a result is never retired and a
// new operand pair accepted on the same edge.
module seq_divider #(
    parameter int DW = 32,
    parameter int VW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_zero
);

    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // FSM state, kept as a named register so checkers can bind to it directly
    state_t state;

    // Working registers. work_q starts as the dividend; each iteration shifts
    // its MSB out into the partial remainder and shifts the new quotient bit
    // in at the LSB, so after DW iterations it holds the quotient.
    logic [DW-1:0] work_q;
    logic [VW-1:0] divisor_q;
    logic [VW:0]   partial_q;
    logic [CW-1:0] count_q;

    // Next-iteration values of the datapath
    logic [VW:0]   partial_shift;
    logic [VW:0]   partial_next;
    logic [DW-1:0] work_next;
    logic          take;

    // One restoring step: shift in the next dividend bit, subtract when it fits.
    // The partial remainder is VW+1 bits: before the shift it is < divisor, so
    // after the shift it is < 2*divisor and the compare cannot overflow.
    always_comb begin
        partial_shift = {partial_q[VW-1:0], work_q[DW-1]};
        take          = (partial_shift >= {1'b0, divisor_q});
        partial_next  = partial_shift;
        if (take) begin
            partial_next = partial_shift - {1'b0, divisor_q};
        end
        work_next = {work_q[DW-2:0], take};
    end

`ifdef DIV_ZERO_DETECT_EN
    logic div_zero_q;
    assign div_zero = div_zero_q;
`else
    assign div_zero = 1'b0;
`endif

    // Control FSM with registered handshake outputs and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            partial_q <= '0;
            count_q   <= '0;
`ifdef DIV_ZERO_DETECT_EN
            div_zero_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        work_q    <= dividend;
                        divisor_q <= divisor;
                        partial_q <= '0;
                        count_q   <= CW'(DW - 1);
                        in_ready  <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
                        if (divisor == '0) begin
                            // Short-cut: publish the divide-by-zero result now
                            state      <= DONE;
                            out_valid  <= 1'b1;
                            quotient   <= '1;
                            remainder  <= dividend[VW-1:0];
                            div_zero_q <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end

                RUN: begin
                    work_q    <= work_next;
                    partial_q <= partial_next;
                    count_q   <= count_q - 1'b1;
                    if (count_q == '0) begin
                        // Last iteration: results become visible only here
                        state     <= DONE;
                        out_valid <= 1'b1;
                        quotient  <= work_next;
                        remainder <= partial_next[VW-1:0];
`ifdef DIV_ZERO_DETECT_EN
                        div_zero_q <= 1'b0;
`endif
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table-driven bench for seq_divider with an expected-result
// queue, plus hand-written sequences for output stall and mid-run reset.
// Builds with or without DIV_ZERO_DETECT_EN.
module tb_seq_divider;

    localparam int DW = 32;
    localparam int VW = 16;
    localparam int TIMEOUT = 100;

`ifdef DIV_ZERO_DETECT_EN
    localparam bit ZD = 1'b1;
`else
    localparam bit ZD = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_zero;

    always #5 clk = ~clk;

    seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [DW-1:0] dvd;
        logic [VW-1:0] dvs;
        logic [DW-1:0] q;
        logic [VW-1:0] r;
    } vec_t;

    vec_t vecs[14];

    logic [DW+VW:0] exp_q[$];   // {quotient, remainder, div_zero}
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks (called at a falling edge) ----------------
    // Present an operand pair, let it be accepted, push the expected result.
    task automatic issue(input logic [DW-1:0] dvd, input logic [VW-1:0] dvs,
                         input logic [DW-1:0] q, input logic [VW-1:0] r);
        logic dz;
        dz = ZD && (dvs == '0);
        in_valid = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        check("in_ready_idle", 64'(in_ready), 64'd1);
        exp_q.push_back({q, r, dz});
        @(negedge clk);
        // Scramble inputs after the accepting edge; the block must ignore them
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = 16'($urandom);
    endtask

    // Count rising edges after the accepting one until out_valid is seen.
    task automatic wait_done(input int exp_lat);
        int lat;
        lat = 0;
        while (!out_valid && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_lat));
    endtask

    // Compare outputs against the queue head, then complete the handshake.
    task automatic take_result();
        logic [DW+VW:0] e;
        if (exp_q.size() == 0) begin
            check("queue_empty", 64'd1, 64'd0);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        check("out_valid", 64'(out_valid), 64'd1);
        check("in_ready_done", 64'(in_ready), 64'd0);
        check("quotient", 64'(quotient), 64'(e[DW+VW:VW+1]));
        check("remainder", 64'(remainder), 64'(e[VW:1]));
        check("div_zero", 64'(div_zero), 64'(e[0]));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_take", 64'(out_valid), 64'd0);
        check("in_ready_after_take", 64'(in_ready), 64'd1);
    endtask

    function automatic int exp_latency(input logic [VW-1:0] dvs);
        return (ZD && dvs == '0) ? 0 : DW;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        logic [DW-1:0] d;
        logic [VW-1:0] v;

        // Vector table: spec cases, boundaries, then random with a / % model
        vecs[0] = '{32'd7006652,  16'd5678,   32'd1234,       16'd0};
        vecs[1] = '{32'd7006655,  16'd5678,   32'd1234,       16'd3};
        vecs[2] = '{32'hFFFF_FFFF, 16'hFFFF,  32'h0001_0001,  16'h0};
        vecs[3] = '{32'h0001_2345, 16'h0000,  32'hFFFF_FFFF,  16'h2345};
        vecs[4] = '{32'hDEAD_BEEF, 16'h0001,  32'hDEAD_BEEF,  16'h0};
        vecs[5] = '{32'd5,         16'd9,     32'd0,          16'd5};
        vecs[6] = '{32'd0,         16'd123,   32'd0,          16'd0};
        vecs[7] = '{32'hFFFF_FFFF, 16'h0002,  32'h7FFF_FFFF,  16'h1};
        for (int i = 8; i < 14; i++) begin
            d = $urandom;
            v = 16'($urandom_range(1, 65535));
            vecs[i].dvd = d;
            vecs[i].dvs = v;
            vecs[i].q   = d / 32'(v);
            vecs[i].r   = 16'(d % 32'(v));
        end

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_quotient", 64'(quotient), 64'd0);
        check("rst_remainder", 64'(remainder), 64'd0);
        check("rst_div_zero", 64'(div_zero), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r);
            wait_done(exp_latency(vecs[i].dvs));
            take_result();
        end

        // Output stall: hold out_ready low 10 cycles, stray in_valid ignored
        issue(32'd7006655, 16'd5678, 32'd1234, 16'd3);
        wait_done(DW);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            dividend = 32'd1000;
            divisor  = 16'd10;
            check("stall_out_valid", 64'(out_valid), 64'd1);
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_quotient", 64'(quotient), 64'd1234);
            check("stall_remainder", 64'(remainder), 64'd3);
            @(negedge clk);
        end
        in_valid = 1'b0;
        take_result();
        check("idle_keeps_quotient", 64'(quotient), 64'd1234);
        @(negedge clk);
        check("idle_no_stray_accept", 64'(in_ready), 64'd1);

        // Reset in the middle of 100/7 aborts with no output
        in_valid = 1'b1;
        dividend = 32'd100;
        divisor  = 16'd7;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (15) @(negedge clk);
        check("mid_run_busy", 64'(in_ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_quotient", 64'(quotient), 64'd0);
        check("abort_remainder", 64'(remainder), 64'd0);
        issue(32'd100, 16'd7, 32'd14, 16'd2);
        wait_done(DW);
        take_result();

        check("queue_drained", 64'(exp_q.size()), 64'd0);

        // ---------------- final report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
